// File: rtl/m_wbarb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// FSM state encoding doubles as the one-hot grant vector.
package m_wbarb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    // Pick the next owner from the two CYC requests; ties use round-robin or master 0
    function automatic state_t f_arb(input logic c0, input logic c1,
                                     input logic last, input logic rr);
        state_t res;
        res = ST_IDLE;
        if (c0 && c1) begin
            if (rr && !last) begin
                res = ST_G1;
            end else begin
                res = ST_G0;
            end
        end else if (c0) begin
            res = ST_G0;
        end else if (c1) begin
            res = ST_G1;
        end else begin
            res = ST_IDLE;
        end
        return res;
    endfunction

endpackage

// File: rtl/m_wbarb_tmo.sv
// Bus-timeout watchdog for m_wbarb2, only instantiated with WBARB_TIMEOUT_EN.
// Fires in the cycle that would be the TIMEOUT-th consecutive unacknowledged strobe.
module m_wbarb_tmo #(
    parameter int TMO_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_clr,
    output logic o_tmo
);

    localparam logic [TMO_W-1:0] LIM = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] r_cnt;

    // ACK always wins over the timeout in the same cycle
    assign o_tmo = i_stb & ~i_ack & (r_cnt == LIM);

    // Stall counter: counts strobed cycles without ACK, clears on any break in the stall
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || i_ack || !i_stb || o_tmo) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/m_wbarb2.sv
// Two-master Wishbone B4 classic arbiter with registered grant (round-robin or fixed priority).
// Optional bus-timeout watchdog enabled by defining WBARB_TIMEOUT_EN.
module m_wbarb2
    import m_wbarb_pkg::*;
#(
    parameter int RR      = 1,
    parameter int TMO_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             m0_CYC_I,
    input  logic             m0_STB_I,
    input  logic             m0_WE_I,
    input  logic [SEL_W-1:0] m0_SEL_I,
    input  logic [ADR_W-1:0] m0_ADR_I,
    input  logic [DAT_W-1:0] m0_DAT_I,
    output logic             m0_ACK_O,
    output logic             m0_ERR_O,
    output logic [DAT_W-1:0] m0_DAT_O,
    input  logic             m1_CYC_I,
    input  logic             m1_STB_I,
    input  logic             m1_WE_I,
    input  logic [SEL_W-1:0] m1_SEL_I,
    input  logic [ADR_W-1:0] m1_ADR_I,
    input  logic [DAT_W-1:0] m1_DAT_I,
    output logic             m1_ACK_O,
    output logic             m1_ERR_O,
    output logic [DAT_W-1:0] m1_DAT_O,
    output logic             CYC_O,
    output logic             STB_O,
    output logic             WE_O,
    output logic [SEL_W-1:0] SEL_O,
    output logic [ADR_W-1:0] ADR_O,
    output logic [DAT_W-1:0] DAT_O,
    input  logic [DAT_W-1:0] DAT_I,
    input  logic             ACK_I,
    output logic [1:0]       gnt
);

    localparam logic RR_EN = (RR != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             w_cyc;
    logic             w_stb;
    logic             w_we;
    logic [SEL_W-1:0] w_sel;
    logic [ADR_W-1:0] w_adr;
    logic [DAT_W-1:0] w_dat;
    logic             w_tmo;

    // Next-state: owner keeps the bus while its CYC is high, otherwise re-arbitrate immediately
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = f_arb(m0_CYC_I, m1_CYC_I, r_last, RR_EN);
            ST_G0: begin
                if (m0_CYC_I) begin
                    w_state_nxt = ST_G0;
                end else begin
                    w_state_nxt = f_arb(m0_CYC_I, m1_CYC_I, r_last, RR_EN);
                end
            end
            ST_G1: begin
                if (m1_CYC_I) begin
                    w_state_nxt = ST_G1;
                end else begin
                    w_state_nxt = f_arb(m0_CYC_I, m1_CYC_I, r_last, RR_EN);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant register; last starts at 1 so master 0 wins the first tie
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE)) begin
                r_last <= (w_state_nxt == ST_G1);
            end else begin
                r_last <= r_last;
            end
        end
    end

    // Slave-side mux of the owner's request; everything zero while idle
    always_comb begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
        w_we  = 1'b0;
        w_sel = '0;
        w_adr = '0;
        w_dat = '0;
        case (r_state)
            ST_G0: begin
                w_cyc = m0_CYC_I;
                w_stb = m0_STB_I;
                w_we  = m0_WE_I;
                w_sel = m0_SEL_I;
                w_adr = m0_ADR_I;
                w_dat = m0_DAT_I;
            end
            ST_G1: begin
                w_cyc = m1_CYC_I;
                w_stb = m1_STB_I;
                w_we  = m1_WE_I;
                w_sel = m1_SEL_I;
                w_adr = m1_ADR_I;
                w_dat = m1_DAT_I;
            end
            default: begin
                w_cyc = 1'b0;
                w_stb = 1'b0;
            end
        endcase
    end

`ifdef WBARB_TIMEOUT_EN
    logic w_gnt_chg;
    assign w_gnt_chg = (w_state_nxt != r_state);

    m_wbarb_tmo #(
        .TMO_W   (TMO_W),
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .i_clk (CLK_I),
        .i_rst (RST_I),
        .i_stb (w_stb),
        .i_ack (ACK_I),
        .i_clr (w_gnt_chg),
        .o_tmo (w_tmo)
    );
`else
    // Watchdog absent: expression is constant 0, parameters only kept for a common interface
    assign w_tmo = (TIMEOUT < 0) && (TMO_W < 0);
`endif

    assign gnt      = r_state;
    assign CYC_O    = w_cyc;
    assign STB_O    = w_stb & ~w_tmo;
    assign WE_O     = w_we;
    assign SEL_O    = w_sel;
    assign ADR_O    = w_adr;
    assign DAT_O    = w_dat;
    assign m0_DAT_O = DAT_I;
    assign m1_DAT_O = DAT_I;
    // A master that has dropped CYC no longer receives ACK
    assign m0_ACK_O = (r_state == ST_G0) & m0_CYC_I & ACK_I;
    assign m1_ACK_O = (r_state == ST_G1) & m1_CYC_I & ACK_I;
    assign m0_ERR_O = (r_state == ST_G0) & w_tmo;
    assign m1_ERR_O = (r_state == ST_G1) & w_tmo;

endmodule

// File: tb/tb_m_wbarb2.sv
// Directed self-checking bench for m_wbarb2: a round-robin instance and a
// fixed-priority instance share the same master/slave stimulus.
module tb_m_wbarb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [31:0] dat_i;
    logic        ack_i;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;
    logic [1:0]  gnt;

    logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
    logic [31:0] f_m0_rd, f_m1_rd;
    logic        f_cyc_o, f_stb_o, f_we_o;
    logic [3:0]  f_sel_o;
    logic [31:0] f_adr_o, f_dat_o;
    logic [1:0]  f_gnt;

    int total = 0;
    int bad   = 0;

`ifdef WBARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    m_wbarb2 #(.RR(1), .TMO_W(8), .TIMEOUT(4)) dut (
        .CLK_I(clk), .RST_I(rst),
        .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we), .m0_SEL_I(m0_sel),
        .m0_ADR_I(m0_adr), .m0_DAT_I(m0_dat), .m0_ACK_O(m0_ack), .m0_ERR_O(m0_err),
        .m0_DAT_O(m0_rd),
        .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we), .m1_SEL_I(m1_sel),
        .m1_ADR_I(m1_adr), .m1_DAT_I(m1_dat), .m1_ACK_O(m1_ack), .m1_ERR_O(m1_err),
        .m1_DAT_O(m1_rd),
        .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .SEL_O(sel_o), .ADR_O(adr_o),
        .DAT_O(dat_o), .DAT_I(dat_i), .ACK_I(ack_i), .gnt(gnt)
    );

    m_wbarb2 #(.RR(0), .TMO_W(8), .TIMEOUT(4)) dut_fp (
        .CLK_I(clk), .RST_I(rst),
        .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we), .m0_SEL_I(m0_sel),
        .m0_ADR_I(m0_adr), .m0_DAT_I(m0_dat), .m0_ACK_O(f_m0_ack), .m0_ERR_O(f_m0_err),
        .m0_DAT_O(f_m0_rd),
        .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we), .m1_SEL_I(m1_sel),
        .m1_ADR_I(m1_adr), .m1_DAT_I(m1_dat), .m1_ACK_O(f_m1_ack), .m1_ERR_O(f_m1_err),
        .m1_DAT_O(f_m1_rd),
        .CYC_O(f_cyc_o), .STB_O(f_stb_o), .WE_O(f_we_o), .SEL_O(f_sel_o), .ADR_O(f_adr_o),
        .DAT_O(f_dat_o), .DAT_I(dat_i), .ACK_I(ack_i), .gnt(f_gnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = 32'h0; m0_dat = 32'h0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = 32'h0; m1_dat = 32'h0;
        dat_i = 32'h0; ack_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mid();
        total++;
        if (gnt !== 2'b00 || f_gnt !== 2'b00) begin
            bad++; $display("FAIL reset_gnt: got %b/%b want 00", gnt, f_gnt);
        end
        total++;
        if ({cyc_o, stb_o, we_o, sel_o} !== 7'h0 || adr_o !== 32'h0 || dat_o !== 32'h0) begin
            bad++; $display("FAIL reset_bus: got cyc%b stb%b we%b sel%h adr%h dat%h want zeros",
                            cyc_o, stb_o, we_o, sel_o, adr_o, dat_o);
        end
        total++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_ackerr: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
        end
    endtask

    task automatic test_single();
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF;
        m0_adr = 32'h0000_1000; m0_dat = 32'h1234_5678;
        mid();
        total++;
        if (gnt !== 2'b00 || cyc_o !== 1'b0) begin
            bad++; $display("FAIL single_latency: got gnt=%b cyc=%b want 00/0", gnt, cyc_o);
        end
        tick();
        mid();
        total++;
        if (gnt !== 2'b01 || cyc_o !== 1'b1 || stb_o !== 1'b1 || adr_o !== 32'h0000_1000) begin
            bad++; $display("FAIL single_grant: got gnt=%b cyc=%b stb=%b adr=%h want 01/1/1/00001000",
                            gnt, cyc_o, stb_o, adr_o);
        end
        total++;
        if (we_o !== 1'b1 || sel_o !== 4'hF || dat_o !== 32'h1234_5678) begin
            bad++; $display("FAIL single_fields: got we=%b sel=%h dat=%h want 1/f/12345678", we_o, sel_o, dat_o);
        end
        tick();
        ack_i = 1'b1; dat_i = 32'hCAFE_0001;
        mid();
        total++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            bad++; $display("FAIL single_ack: got m0=%b m1=%b want 1/0", m0_ack, m1_ack);
        end
        total++;
        if (m0_rd !== 32'hCAFE_0001 || m1_rd !== 32'hCAFE_0001) begin
            bad++; $display("FAIL single_rdata: got %h/%h want cafe0001", m0_rd, m1_rd);
        end
        tick();
        ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        mid();
        total++;
        if (gnt !== 2'b01 || m0_ack !== 1'b0) begin
            bad++; $display("FAIL single_drop: got gnt=%b ack=%b want 01/0", gnt, m0_ack);
        end
        tick();
        mid();
        total++;
        if (gnt !== 2'b00 || adr_o !== 32'h0) begin
            bad++; $display("FAIL single_idle: got gnt=%b adr=%h want 00/0", gnt, adr_o);
        end
    endtask

    task automatic test_tie();
        logic [1:0] exp_rr [3];
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01;
        do_reset();
        m0_adr = 32'h0000_A000; m1_adr = 32'h0000_B000;
        for (int k = 0; k < 3; k++) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
            tick();
            mid();
            total++;
            if (gnt !== exp_rr[k]) begin
                bad++; $display("FAIL tie_rr%0d: got %b want %b", k, gnt, exp_rr[k]);
            end
            total++;
            if (f_gnt !== 2'b01) begin
                bad++; $display("FAIL tie_fixed%0d: got %b want 01", k, f_gnt);
            end
            total++;
            if (adr_o !== ((exp_rr[k] == 2'b01) ? 32'h0000_A000 : 32'h0000_B000)) begin
                bad++; $display("FAIL tie_adr%0d: got %h", k, adr_o);
            end
            m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            tick();
        end
    endtask

    task automatic test_handoff();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_3000;
        tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_2000;
        tick();
        mid();
        total++;
        if (gnt !== 2'b01 || adr_o !== 32'h0000_3000) begin
            bad++; $display("FAIL handoff_hold: got gnt=%b adr=%h want 01/00003000", gnt, adr_o);
        end
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        mid();
        total++;
        if (gnt !== 2'b01) begin
            bad++; $display("FAIL handoff_n: got %b want 01", gnt);
        end
        tick();
        mid();
        total++;
        if (gnt !== 2'b10 || adr_o !== 32'h0000_2000 || cyc_o !== 1'b1) begin
            bad++; $display("FAIL handoff_n1: got gnt=%b adr=%h cyc=%b want 10/00002000/1", gnt, adr_o, cyc_o);
        end
    endtask

    task automatic test_abandon();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        mid();
        total++;
        if (m1_ack !== 1'b0) begin
            bad++; $display("FAIL abandon_drop: got ack=%b want 0", m1_ack);
        end
        tick();
        ack_i = 1'b1;
        mid();
        total++;
        if (gnt !== 2'b00 || m1_ack !== 1'b0 || m0_ack !== 1'b0) begin
            bad++; $display("FAIL abandon_late_ack: got gnt=%b m0=%b m1=%b want 00/0/0", gnt, m0_ack, m1_ack);
        end
        tick();
        ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_4000;
        tick();
        mid();
        total++;
        if (gnt !== 2'b10 || adr_o !== 32'h0000_4000) begin
            bad++; $display("FAIL rstmid_grant: got gnt=%b adr=%h want 10/00004000", gnt, adr_o);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; ack_i = 1'b1;
        mid();
        total++;
        if (gnt !== 2'b00 || cyc_o !== 1'b0 || stb_o !== 1'b0 || adr_o !== 32'h0) begin
            bad++; $display("FAIL rstmid_bus: got gnt=%b cyc=%b stb=%b adr=%h want 00/0/0/0",
                            gnt, cyc_o, stb_o, adr_o);
        end
        total++;
        if (m1_ack !== 1'b0 || m0_ack !== 1'b0) begin
            bad++; $display("FAIL rstmid_ack: got m0=%b m1=%b want 0/0", m0_ack, m1_ack);
        end
        tick();
        ack_i = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic exp_err;
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_5000;
        tick();
        for (int c = 1; c <= 7; c++) begin
            exp_err = TMO_EN && (c == 4);
            mid();
            total++;
            if (m0_err !== exp_err || stb_o !== !exp_err || m1_err !== 1'b0) begin
                bad++; $display("FAIL timeout_c%0d: got err=%b stb=%b m1err=%b want %b/%b/0",
                                c, m0_err, stb_o, m1_err, exp_err, !exp_err);
            end
            tick();
        end
        ack_i = 1'b1;
        mid();
        total++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin
            bad++; $display("FAIL timeout_ack_wins: got ack=%b err=%b want 1/0", m0_ack, m0_err);
        end
        tick();
        ack_i = 1'b0;
        mid();
        total++;
        if (m0_err !== 1'b0 || stb_o !== 1'b1) begin
            bad++; $display("FAIL timeout_after_ack: got err=%b stb=%b want 0/1", m0_err, stb_o);
        end
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_handoff();
        test_abandon();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_wbarb2.md
# m_wbarb2

Two-master Wishbone B4 classic arbiter that shares the single midgetv bus port (CYC_O/STB_O/WE_O/SEL_O/ADR_O/DAT_O/DAT_I/ACK_I) between the midgetv core (master 0) and a loader/debug master (master 1). It sits between `m_midgetv_core` and the system interconnect. Grant is registered, held for the whole CYC_O cycle and rotated round-robin or by fixed priority. An optional bus-timeout watchdog terminates a stalled access with an error.

## Interface
Parameters:
- RR, 1, 1 = round-robin on ties; 0 = fixed priority, master 0 wins.
- TMO_W, 8, width of the timeout counter.
- TIMEOUT, 255, number of unacknowledged STB_O cycles before ERR. Must be ≤ 2^TMO_W−1.

Ports:
- CLK_I  in  1  single clock; all state updates on the rising edge.
- RST_I  in  1  synchronous, active-high reset.
- mN_CYC_I, mN_STB_I, mN_WE_I  in  1 each  master N request (N = 0, 1).
- mN_SEL_I  in  4  master N byte select.
- mN_ADR_I  in  32  master N address.
- mN_DAT_I  in  32  master N write data.
- mN_ACK_O  out  1  acknowledge to master N.
- mN_ERR_O  out  1  error termination to master N.
- mN_DAT_O  out  32  read data to master N. This is DAT_I broadcast to both masters.
- CYC_O, STB_O, WE_O  out  1 each  slave-side strobes.
- SEL_O  out  4  slave-side byte select.
- ADR_O  out  32  slave-side address.
- DAT_O  out  32  slave-side write data.
- DAT_I  in  32  slave read data.
- ACK_I  in  1  slave acknowledge.
- gnt  out  2  one-hot current owner; 00 = idle.

## Operation
- Three-state FSM on a registered grant: IDLE, G0, G1. Reset enters IDLE and sets the `last` bit to 1, so master 0 wins the first tie.
- IDLE: only m0_CYC_I is high → G0. Only m1_CYC_I is high → G1.
  - Both high with RR=1: grant the master ≠ `last`.
  - Both high with RR=0: → G0.
- Gx: stay while mx_CYC_I is high. When mx_CYC_I is low, arbitrate exactly as in IDLE, so handoff to the other master needs no dead cycle. Otherwise → IDLE.
- `last` is updated to the newly granted index on every entry into G0/G1.
- Slave-side outputs are a combinational mux of the owner's signals:
  - CYC_O = owner CYC; STB_O = owner STB.
  - Other signals come from the owner.
  - In IDLE all outputs are 0 and ADR_O = 0.
- ACK_I is forwarded only to the owner. The non-owner's ACK_O and ERR_O are always 0.
- A master that drops CYC mid-access forfeits the grant. Any late ACK_I is discarded.
- Grant transition width rule: gnt is one-hot or zero, never 11.

## Timing
- Request latency: mx_CYC_I rises in cycle n with the FSM in IDLE → gnt and CYC_O valid in cycle n+1. That is one cycle.
- ACK path is combinational: ACK_I → mx_ACK_O in the same cycle, zero latency.
- Handoff: owner drops CYC in cycle n while the other master requests → other master is granted in cycle n+1.
- Reset output values: gnt=00, CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0, all mN_ACK_O/mN_ERR_O=0, timeout counter=0.
- RST_I mid-access: the next cycle is IDLE with all outputs at reset values. The pending access is abandoned and no ACK is delivered.

## Configuration
- Macro: `WBARB_TIMEOUT_EN`.
- Defined:
  - The counter increments each cycle with STB_O=1 and ACK_I=0.
  - It clears on ACK_I, on grant change, and when STB_O=0.
  - When the counter reaches TIMEOUT, the owner's ERR_O pulses for one cycle and STB_O is forced to 0 in that cycle. The counter then clears.
  - ACK_I in the same cycle takes precedence: ACK, no ERR.
- Not defined: no counter, all mN_ERR_O tied 0, TMO_W and TIMEOUT are ignored.

## Structure
- Shared package `m_wbarb_pkg`:
  - FSM state encoding, IDLE=2'b00, G0=2'b01, G1=2'b10, identical to gnt.
  - Wishbone width constants: ADR 32, DAT 32, SEL 4.
- One sub-module, `m_wbarb_tmo`, holds the timeout counter and comparator. It is instantiated only under `WBARB_TIMEOUT_EN`.

## Test plan
- Reset and single master: reset, then m0 CYC/STB at ADR 0x0000_1000 with ACK after 2 cycles → gnt=01 the next cycle, m0_ACK_O pulses, m1_ACK_O stays 0. After m0 drops CYC, gnt=00.
- Tie: m0 and m1 raise CYC in the same cycle, with RR=1 after reset → G0. Next tie → G1, then G0. With RR=0, every tie → G0.
- Handoff: m0 drops CYC in cycle n while m1 is requesting → gnt=10 in cycle n+1 with no idle cycle, and ADR_O switches to m1_ADR_I.
- Abandon: m1 drops CYC while ACK is pending, and the slave ACKs one cycle later → m1_ACK_O=0 and m0_ACK_O=0.
- Reset mid-access: RST_I pulses during a G1 access → the next cycle has gnt=00, CYC_O=0, ADR_O=0, and no ACK is delivered.
- Timeout (`WBARB_TIMEOUT_EN`, TIMEOUT=4): m0 strobes with no ACK → m0_ERR_O pulses on the 4th stalled cycle and STB_O=0 that cycle. An ACK on the 4th cycle instead gives ACK with no ERR.
